// File: rtl/addsub_pkg.sv
// Shared types and helpers for the chunked sequential adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the chunk index counter; a single-chunk build still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_addsub_chunked_chunk_adder.sv
// Combinational CHUNK-bit ripple adder slice. Exposes the carry into its top
// bit so the parent can form signed overflow on the last chunk.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_chunk,
  input  logic [CHUNK-1:0] b_chunk,
  input  logic             cin,
  output logic [CHUNK-1:0] s_chunk,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s_chunk[i] = a_chunk[i] ^ b_chunk[i] ^ c[i];
    assign c[i+1]     = (a_chunk[i] & b_chunk[i]) | (c[i] & (a_chunk[i] ^ b_chunk[i]));
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/seq_addsub_chunked.sv
// Multi-cycle two's-complement adder/subtractor. Adds CHUNK bits per clock
// through a registered carry so wide operands keep a short combinational path.
// Valid/ready on both sides; one operation in flight at a time.
module seq_addsub_chunked
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = idx_w(NCHUNK);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [IW-1:0]    idx_q, idx_d;

  logic [31:0]      base;
  logic [CHUNK-1:0] a_ch, b_ch, s_ch;
  logic             ch_cout, ch_cmsb;
  logic             last;

  assign base = 32'(idx_q) * 32'(CHUNK);
  assign a_ch = a_q[base +: CHUNK];
  assign b_ch = b_q[base +: CHUNK];
  assign last = (idx_q == LAST);

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a_chunk  (a_ch),
    .b_chunk  (b_ch),
    .cin      (carry_q),
    .s_chunk  (s_ch),
    .cout     (ch_cout),
    .c_msb_in (ch_cmsb)
  );

  // State register; reset aborts any operation in progress.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CALC;
      CALC:    if (last)     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath next-state: latch operands on accept, fold one chunk per CALC cycle.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: if (in_valid) begin
        // Subtraction as a + ~b + 1: invert b once here, seed carry with sub.
        a_d     = a;
        b_d     = sub ? ~b : b;
        carry_d = sub;
        idx_d   = '0;
      end
      CALC: begin
        sum_d[base +: CHUNK] = s_ch;
        carry_d              = ch_cout;
        idx_d                = last ? '0 : idx_q + 1'b1;
        if (last) begin
          cout_d = ch_cout;
          ovf_d  = ch_cmsb ^ ch_cout;
          zero_d = (sum_d == '0);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; results hold across DONE and IDLE until the next op.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign sum      = sum_q;
  assign carryout = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_seq_addsub_chunked.sv
// Bench for seq_addsub_chunked: three builds (8/2, 32/32, 32/1) share one
// scoreboard; slot k selects the instance.
module tb_seq_addsub_chunked;

  typedef struct {
    int          k;
    logic [31:0] s;
    logic        c, o, z;
  } res_t;

  typedef struct {
    logic [7:0] a, b;
    logic       sub;
    logic [7:0] s;
    logic       c, o, z;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rstn, iv, sb, ordy;
  logic [2:0][31:0] a, b;
  wire  [2:0]       ir, ov, co, of, zr;
  wire  [7:0]       s0;
  wire  [31:0]      s1, s2;

  int checks, errors;
  res_t sbq[$];

  seq_addsub_chunked #(.WIDTH(8), .CHUNK(2)) u0 (
    .clk(clk), .reset_n(rstn[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a[0][7:0]), .b(b[0][7:0]), .sub(sb[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .sum(s0), .carryout(co[0]), .overflow(of[0]), .zero(zr[0]));

  seq_addsub_chunked #(.WIDTH(32), .CHUNK(32)) u1 (
    .clk(clk), .reset_n(rstn[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a[1]), .b(b[1]), .sub(sb[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .sum(s1), .carryout(co[1]), .overflow(of[1]), .zero(zr[1]));

  seq_addsub_chunked #(.WIDTH(32), .CHUNK(1)) u2 (
    .clk(clk), .reset_n(rstn[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a[2]), .b(b[2]), .sub(sb[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .sum(s2), .carryout(co[2]), .overflow(of[2]), .zero(zr[2]));

  function automatic logic [31:0] sum_of(input int k);
    case (k)
      0:       return {24'h0, s0};
      1:       return s1;
      default: return s2;
    endcase
  endfunction

  function automatic int width_of(input int k);
    return (k == 0) ? 8 : 32;
  endfunction

  function automatic int lat_of(input int k);
    case (k)
      0:       return 4;
      1:       return 1;
      default: return 32;
    endcase
  endfunction

  // Reference: plain modular add on a wide accumulator, overflow from sign rule.
  function automatic res_t model(input int k, input logic [31:0] av, input logic [31:0] bv,
                                 input logic sv);
    res_t        r;
    int          w;
    logic [63:0] m, acc, op_b;
    w     = width_of(k);
    m     = (64'd1 << w) - 64'd1;
    op_b  = sv ? (~{32'h0, bv}) & m : {32'h0, bv} & m;
    acc   = ({32'h0, av} & m) + op_b + {63'h0, sv};
    r.k   = k;
    r.s   = 32'(acc & m);
    r.c   = acc[w];
    r.o   = (av[w-1] == op_b[w-1]) && (r.s[w-1] != av[w-1]);
    r.z   = (r.s == 32'h0);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: pop and compare whenever a result transfer is about to happen.
  always @(negedge clk) begin
    res_t e;
    for (int k = 0; k < 3; k++) begin
      if (rstn[k] && ov[k] && ordy[k]) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_result", 32'(k), 32'hFFFF_FFFF);
        end else begin
          e = sbq.pop_front();
          chk("sb_slot", 32'(k), 32'(e.k));
          chk("sb_sum", sum_of(k), e.s);
          chk("sb_carry", {31'h0, co[k]}, {31'h0, e.c});
          chk("sb_ovf", {31'h0, of[k]}, {31'h0, e.o});
          chk("sb_zero", {31'h0, zr[k]}, {31'h0, e.z});
        end
      end
    end
  end

  // Issue one op on slot k, check latency, optionally stall the result for hold cycles.
  task automatic do_op(input int k, input logic [31:0] av, input logic [31:0] bv,
                       input logic sv, input res_t e, input int hold);
    int n;
    n = 0;
    while (!ir[k] && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("wait_in_ready", {31'h0, ir[k]}, 32'h1);
    a[k] = av; b[k] = bv; sb[k] = sv; iv[k] = 1'b1;
    ordy[k] = (hold == 0);
    sbq.push_back(e);
    @(posedge clk); #1;
    // Scramble inputs after the accept edge; the op must not see them.
    iv[k] = 1'b0; a[k] = $urandom; b[k] = $urandom; sb[k] = 1'($urandom);
    n = 0;
    while (!ov[k] && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", 32'(n), 32'(lat_of(k)));
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        chk("bp_out_valid", {31'h0, ov[k]}, 32'h1);
        chk("bp_in_ready", {31'h0, ir[k]}, 32'h0);
        chk("bp_sum", sum_of(k), e.s);
        chk("bp_flags", {29'h0, co[k], of[k], zr[k]}, {29'h0, e.c, e.o, e.z});
        a[k] = $urandom; b[k] = $urandom; sb[k] = 1'($urandom); iv[k] = 1'($urandom);
        @(posedge clk); #1;
      end
      iv[k] = 1'b0;
      ordy[k] = 1'b1;
    end
    @(posedge clk); #1;
    chk("drop_out_valid", {31'h0, ov[k]}, 32'h0);
    chk("idle_in_ready", {31'h0, ir[k]}, 32'h1);
  endtask

  initial begin
    vec_t tv[6];
    res_t e;
    logic [31:0] ra, rb;
    logic        rs;

    tv[0] = '{a:8'h7F, b:8'h01, sub:1'b0, s:8'h80, c:1'b0, o:1'b1, z:1'b0};
    tv[1] = '{a:8'hFF, b:8'h01, sub:1'b0, s:8'h00, c:1'b1, o:1'b0, z:1'b1};
    tv[2] = '{a:8'h00, b:8'h01, sub:1'b1, s:8'hFF, c:1'b0, o:1'b0, z:1'b0};
    tv[3] = '{a:8'h80, b:8'h01, sub:1'b1, s:8'h7F, c:1'b1, o:1'b1, z:1'b0};
    tv[4] = '{a:8'h05, b:8'h05, sub:1'b1, s:8'h00, c:1'b1, o:1'b0, z:1'b1};
    tv[5] = '{a:8'h3C, b:8'h45, sub:1'b0, s:8'h81, c:1'b0, o:1'b1, z:1'b0};

    checks = 0; errors = 0;
    rstn = '0; iv = '0; sb = '0; ordy = '1; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_out_valid", {31'h0, ov[k]}, 32'h0);
      chk("rst_in_ready", {31'h0, ir[k]}, 32'h1);
      chk("rst_sum", sum_of(k), 32'h0);
      chk("rst_flags", {29'h0, co[k], of[k], zr[k]}, 32'h0);
    end
    rstn = '1;

    // Directed vectors on the 8/2 build; one of them under 10 cycles of backpressure.
    for (int i = 0; i < 6; i++) begin
      e = '{k:0, s:{24'h0, tv[i].s}, c:tv[i].c, o:tv[i].o, z:tv[i].z};
      do_op(0, {24'h0, tv[i].a}, {24'h0, tv[i].b}, tv[i].sub, e, (i == 2) ? 10 : 0);
    end

    // Reset during chunk index 1 aborts the op.
    a[0] = 32'h12; b[0] = 32'h34; sb[0] = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    rstn[0] = 1'b0;
    @(posedge clk); #1;
    rstn[0] = 1'b1;
    chk("midrst_out_valid", {31'h0, ov[0]}, 32'h0);
    chk("midrst_in_ready", {31'h0, ir[0]}, 32'h1);
    chk("midrst_sum", sum_of(0), 32'h0);
    chk("midrst_flags", {29'h0, co[0], of[0], zr[0]}, 32'h0);
    e = '{k:0, s:32'h08, c:1'b0, o:1'b0, z:1'b0};
    do_op(0, 32'h05, 32'h03, 1'b0, e, 0);

    // Random ops on the single-cycle and bit-serial builds.
    for (int k = 1; k < 3; k++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = $urandom; rb = $urandom; rs = 1'($urandom);
        if (i == 0) begin ra = 32'h7FFF_FFFF; rb = 32'h1; rs = 1'b0; end
        if (i == 1) begin ra = 32'h8000_0000; rb = 32'h1; rs = 1'b1; end
        if (i == 2) begin ra = 32'hDEAD_BEEF; rb = 32'hDEAD_BEEF; rs = 1'b1; end
        e = model(k, ra, rb, rs);
        do_op(k, ra, rb, rs, e, ($urandom_range(0, 19) == 0) ? 2 : 0);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sbq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
